// File: rtl/disp_pkg.sv
// Shared types and width helpers for the stereo row scanner.
package disp_pkg;

  // Scanner control states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    SCAN   = 3'd2,
    EMIT   = 3'd3,
    FINISH = 3'd4
  } state_t;

  // Width that holds a full-window SAD of maximal pixel differences without wrap.
  function automatic int sad_bits(input int win, input int data_size);
    return $clog2(win * win * ((1 << data_size) - 1) + 1);
  endfunction

  // Width of a disparity index 0..max_disp-1 (at least one bit).
  function automatic int disp_bits(input int max_disp);
    return (max_disp > 1) ? $clog2(max_disp) : 1;
  endfunction

  // Width of a column index 0..img_w-1 (at least one bit).
  function automatic int col_bits(input int img_w);
    return (img_w > 1) ? $clog2(img_w) : 1;
  endfunction

endpackage

// File: rtl/sad_window.sv
// Sum of absolute differences between two WIN x WIN pixel windows,
// registered so the result appears one cycle after the windows are presented.
module sad_window
  import disp_pkg::*;
#(
  parameter  int WIN       = 15,
  parameter  int DATA_SIZE = 8,
  localparam int SAD_BITS  = sad_bits(WIN, DATA_SIZE),
  localparam int WIN_W     = WIN * WIN * DATA_SIZE
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WIN_W-1:0]    win_a,
  input  logic [WIN_W-1:0]    win_b,
  output logic [SAD_BITS-1:0] sad
);

  logic [SAD_BITS-1:0]  sum;
  logic [DATA_SIZE-1:0] pa;
  logic [DATA_SIZE-1:0] pb;
  logic [DATA_SIZE-1:0] diff;

  // Accumulate |a-b| over every pixel at full SAD width so the sum never wraps.
  always_comb begin
    sum  = '0;
    pa   = '0;
    pb   = '0;
    diff = '0;
    for (int i = 0; i < WIN * WIN; i++) begin
      pa   = win_a[i*DATA_SIZE +: DATA_SIZE];
      pb   = win_b[i*DATA_SIZE +: DATA_SIZE];
      diff = (pa > pb) ? (pa - pb) : (pb - pa);
      sum  = sum + SAD_BITS'(diff);
    end
  end

  // Register the window sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sad <= '0;
    end else begin
      sad <= sum;
    end
  end

endmodule

// File: rtl/disp_row_scanner.sv
// Sweeps a column range of a latched WIN-row stereo band and emits, per column,
// the disparity with the lowest SAD (ties keep the lowest disparity).
// Output handshake: a result transfers on a rising edge where out_valid and
// out_ready are both high; while out_valid is high and out_ready is low the
// result fields hold steady, and out_valid never drops without a transfer.
module disp_row_scanner
  import disp_pkg::*;
#(
  parameter  int WIN       = 15,
  parameter  int DATA_SIZE = 8,
  parameter  int IMG_W     = 64,
  parameter  int MAX_DISP  = 64,
  localparam int SAD_BITS  = sad_bits(WIN, DATA_SIZE),
  localparam int DISP_BITS = disp_bits(MAX_DISP),
  localparam int COL_BITS  = col_bits(IMG_W),
  localparam int BAND_W    = DATA_SIZE * IMG_W * WIN
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 input_ready,
  input  logic [BAND_W-1:0]    input_array_L,
  input  logic [BAND_W-1:0]    input_array_R,
  input  logic [COL_BITS-1:0]  col_start,
  input  logic [COL_BITS-1:0]  col_end,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [COL_BITS-1:0]  out_col,
  output logic [DISP_BITS-1:0] out_disp,
  output logic [SAD_BITS-1:0]  out_sad,
  output logic                 out_invalid,
  output logic                 done,
  output state_t               dbg_state
);

  localparam int HALF  = WIN / 2;
  localparam int WIN_W = WIN * WIN * DATA_SIZE;

  state_t               state;
  logic [BAND_W-1:0]    band_l;
  logic [BAND_W-1:0]    band_r;
  logic [COL_BITS-1:0]  col;
  logic [COL_BITS-1:0]  col_last;
  logic [DISP_BITS-1:0] d_iss;
  logic [DISP_BITS-1:0] pend_d;
  logic [DISP_BITS-1:0] best_d;
  logic [SAD_BITS-1:0]  best_sad;
  logic                 issue_on;
  logic                 pend_on;
  logic [WIN_W-1:0]     win_l;
  logic [WIN_W-1:0]     win_r;
  logic [SAD_BITS-1:0]  sad;
  logic                 take;
  logic [SAD_BITS-1:0]  nxt_best_sad;
  logic [DISP_BITS-1:0] nxt_best_d;
  logic                 last_issue;
  int                   xl;
  int                   xr;

  assign dbg_state = state;

  // Cut the left window centred at col and the right window centred at col-d
  // out of the latched bands; pixels outside the row read as zero.
  always_comb begin
    win_l = '0;
    win_r = '0;
    xl    = 0;
    xr    = 0;
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN; c++) begin
        xl = int'(col) - HALF + c;
        xr = xl - int'(d_iss);
        if (xl >= 0 && xl < IMG_W)
          win_l[(r*WIN+c)*DATA_SIZE +: DATA_SIZE] = band_l[(r*IMG_W+xl)*DATA_SIZE +: DATA_SIZE];
        if (xr >= 0 && xr < IMG_W)
          win_r[(r*WIN+c)*DATA_SIZE +: DATA_SIZE] = band_r[(r*IMG_W+xr)*DATA_SIZE +: DATA_SIZE];
      end
    end
  end

  sad_window #(
    .WIN       (WIN),
    .DATA_SIZE (DATA_SIZE)
  ) u_sad (
    .clk   (clk),
    .rst_n (rst_n),
    .win_a (win_l),
    .win_b (win_r),
    .sad   (sad)
  );

  // Fold the SAD that has just come out of the pipeline into the running best;
  // strict less-than keeps the lowest disparity on ties.
  always_comb begin
    take         = pend_on && (sad < best_sad);
    nxt_best_sad = take ? sad : best_sad;
    nxt_best_d   = take ? pend_d : best_d;
    last_issue   = (int'(d_iss) == MAX_DISP - 1) ||
                   (int'(col) - HALF - int'(d_iss) - 1 < 0);
  end

  // Scanner FSM: latch job, check border, issue candidates, emit, finish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      band_l      <= '0;
      band_r      <= '0;
      col         <= '0;
      col_last    <= '0;
      d_iss       <= '0;
      pend_d      <= '0;
      best_d      <= '0;
      best_sad    <= '0;
      issue_on    <= 1'b0;
      pend_on     <= 1'b0;
      busy        <= 1'b0;
      out_valid   <= 1'b0;
      out_col     <= '0;
      out_disp    <= '0;
      out_sad     <= '0;
      out_invalid <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (input_ready) begin
            band_l   <= input_array_L;
            band_r   <= input_array_R;
            col      <= col_start;
            col_last <= col_end;
            if (col_end < col_start) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              busy  <= 1'b1;
              state <= CHECK;
            end
          end
        end
        CHECK: begin
          if (int'(col) < HALF || int'(col) > IMG_W - 1 - HALF) begin
            out_valid   <= 1'b1;
            out_col     <= col;
            out_disp    <= '0;
            out_sad     <= '0;
            out_invalid <= 1'b1;
            state       <= EMIT;
          end else begin
            d_iss    <= '0;
            issue_on <= 1'b1;
            pend_on  <= 1'b0;
            best_sad <= '1;
            best_d   <= '0;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (pend_on) begin
            best_sad <= nxt_best_sad;
            best_d   <= nxt_best_d;
          end
          if (issue_on) begin
            pend_on <= 1'b1;
            pend_d  <= d_iss;
            if (last_issue) issue_on <= 1'b0;
            else            d_iss    <= d_iss + DISP_BITS'(1);
          end else begin
            pend_on     <= 1'b0;
            out_valid   <= 1'b1;
            out_col     <= col;
            out_disp    <= nxt_best_d;
            out_sad     <= nxt_best_sad;
            out_invalid <= 1'b0;
            state       <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (col == col_last) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              col   <= col + COL_BITS'(1);
              state <= CHECK;
            end
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
